// File: rtl/multdiv_seq.sv
// ============================================================================
// multdiv_seq : sequential 32-bit signed multiply (radix-2 Booth) / divide
//               (restoring on magnitudes); optional MULTDIV_DIV0_FAST_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             w_last;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_mul_ovf;

  assign w_last  = (cnt_q == CNT_W'(WIDTH - 1));
  // Accumulator carries one guard bit so A-=M cannot overflow for M = -2^(W-1).
  assign w_m_ext = {m_q[WIDTH-1], m_q};
  assign w_r_sh  = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign w_diff  = w_r_sh - {1'b0, m_q};
  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_mul_ovf = (acc_q[WIDTH-1:0] != {WIDTH{qr_q[WIDTH-1]}});

  always_comb begin
    w_booth_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   w_booth_sum = acc_q + w_m_ext;
      2'b10:   w_booth_sum = acc_q - w_m_ext;
      default: w_booth_sum = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_MULT) begin
          acc_d    = '0;
          qr_d     = data_operandB;
          qm1_d    = 1'b0;
          m_d      = data_operandA;
          op_div_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_MUL;
        end else if (ctrl_DIV) begin
          acc_d    = '0;
          qr_d     = w_abs_a;
          m_d      = w_abs_b;
          neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          op_div_d = 1'b1;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_DIV;
`ifdef MULTDIV_DIV0_FAST_EN
          if (data_operandB == '0) begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_MUL: begin
        acc_d  = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        qr_d   = {w_booth_sum[0], qr_q[WIDTH-1:1]};
        qm1_d  = qr_q[0];
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (w_last) state_d = S_DONE;
      end
      S_DIV: begin
        if (w_diff[WIDTH]) begin
          acc_d = w_r_sh;
          qr_d  = {qr_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = w_diff;
          qr_d  = {qr_q[WIDTH-2:0], 1'b1};
        end
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (w_last) state_d = S_DONE;
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
        if (op_div_q) begin
          if (m_q == '0) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            // A positive quotient with the MSB set only arises from MIN / -1.
            res_d = neg_q ? -qr_q : qr_q;
            exc_d = ~neg_q & qr_q[WIDTH-1];
          end
        end else begin
          res_d = qr_q;
          exc_d = w_mul_ovf;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_seq.sv
// ============================================================================
// tb_multdiv_seq : self-checking bench for multdiv_seq (vector table,
//                  hand sequences, random ops against an arithmetic model).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_seq;

`ifdef MULTDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] opA, opB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_cmp = 0;
  int n_bad = 0;

  multdiv_seq dut (
    .clk            (clk),
    .rst            (rst),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference built from plain signed arithmetic.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint p;
    int     sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (!is_div) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && sb == -1) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = 32'(sa / sb);
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    opA       = a;
    opB       = b;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    opA       = $urandom;
    opB       = $urandom;
  endtask

  // Counts edges from the start edge until RDY is seen; busy must hold meanwhile.
  task automatic wait_rdy(input int start, output int lat, output bit busy_ok);
    lat     = start;
    busy_ok = 1'b1;
    forever begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (data_resultRDY === 1'b1) break;
      if (lat >= 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdy_timeout: got no RDY after %0d edges, required one", lat);
        break;
      end
    end
  endtask

  task automatic run_check(input string nm, input bit is_div, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input bit ee);
    int lat;
    bit bok;
    int elat;
    elat = (is_div && b == 32'h0) ? DIV0_LAT : 33;
    start_op(!is_div, is_div, a, b);
    wait_rdy(0, lat, bok);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_res"}, data_result, er);
    chk({nm, "_exc"}, {31'h0, data_exception}, {31'h0, ee});
    @(posedge clk);
    #1;
    chk({nm, "_rdy_pulse"}, {31'h0, data_resultRDY}, 32'h0);
  endtask

  initial begin
    vec_t        vecs[10];
    int          lat;
    bit          bok;
    bit          seen;
    logic [31:0] er, ra, rb;
    bit          ee, rdiv;

    vecs[0] = '{1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7] = '{1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1};
    vecs[8] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};

    rst = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    opA = 32'h0;
    opB = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res",  data_result, 32'h0);
    chk("reset_exc",  {31'h0, data_exception}, 32'h0);
    chk("reset_rdy",  {31'h0, data_resultRDY}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;

    // 7 x -3 with busy tracking across the whole operation
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_rdy(0, lat, bok);
    chk("m7x3_lat", lat, 33);
    chk("m7x3_busy_run", {31'h0, bok}, 32'h1);
    chk("m7x3_busy_rdy", {31'h0, busy}, 32'h1);
    chk("m7x3_res", data_result, 32'hFFFF_FFEB);
    chk("m7x3_exc", {31'h0, data_exception}, 32'h0);
    @(posedge clk);
    #1;
    chk("m7x3_rdy_pulse", {31'h0, data_resultRDY}, 32'h0);
    chk("m7x3_busy_after", {31'h0, busy}, 32'h0);
    chk("m7x3_hold", data_result, 32'hFFFF_FFEB);

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].exc);

    // ctrl_DIV pulse at E5 of a multiply is ignored
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    ctrl_DIV = 1'b1;
    opA = 32'd100;
    opB = 32'd3;
    @(posedge clk);
    #1;
    ctrl_DIV = 1'b0;
    wait_rdy(5, lat, bok);
    chk("midop_lat", lat, 33);
    chk("midop_res", data_result, 32'd15);
    @(posedge clk);
    #1;

    // both starts together: multiply wins; then start on the RDY cycle (E34)
    start_op(1'b1, 1'b1, 32'd4, 32'hFFFF_FFFE);
    wait_rdy(0, lat, bok);
    chk("both_res", data_result, 32'hFFFF_FFF8);
    chk("both_exc", {31'h0, data_exception}, 32'h0);
    ctrl_MULT = 1'b1;
    opA = 32'd6;
    opB = 32'd6;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    opA = 32'h0;
    opB = 32'h0;
    wait_rdy(0, lat, bok);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", data_result, 32'd36);
    @(posedge clk);
    #1;

    // reset at E10 of a divide discards the operation
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_res",  data_result, 32'h0);
    chk("midrst_rdy",  {31'h0, data_resultRDY}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_rdy", {31'h0, seen}, 32'h0);
    run_check("after_rst", 1'b0, 32'd2, 32'd3, 32'd6, 1'b0);

    // random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($signed($urandom_range(0, 30)) - 15);
        3:       begin ra = 32'h8000_0000; rb = $urandom; end
        4:       rb = {16'h0, 16'($urandom)};
        default: rb = $urandom;
      endcase
      model(rdiv, ra, rb, er, ee);
      run_check($sformatf("rnd%0d", i), rdiv, ra, rb, er, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
